// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared constants for the iterative shift-add multiplier.
//   Provides the FSM state encoding, the default operand width and the
//   radix-2 Booth decode codes (used only when SEQ_MUL_SIGNED_EN is defined).
package seq_mul_pkg;

  // Default operand width; the product is 2*WIDTH bits and takes WIDTH steps.
  localparam int SEQ_MUL_WIDTH = 16;

  // FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Booth decode on {MR[0], q_m1}.
  localparam logic [1:0] BOOTH_NOP0 = 2'b00;
  localparam logic [1:0] BOOTH_ADD  = 2'b01;
  localparam logic [1:0] BOOTH_SUB  = 2'b10;
  localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/mul_step.sv
// mul_step: one combinational iteration of the ACC:MR multiplier.
//   Ports: acc/mr/md in -> acc_nxt/mr_nxt out (plus q_m1/q_m1_nxt in the
//   signed build). Optional macro SEQ_MUL_SIGNED_EN selects radix-2 Booth.
module mul_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mr,
  input  logic [WIDTH-1:0] md,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic             q_m1,
  output logic             q_m1_nxt,
`endif
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] mr_nxt
);

  // WIDTH+1 bit partial sum: the extra bit is the carry (unsigned) or the
  // true sign (signed), so the product stays exact even for -2^(W-1) operands.
  logic [WIDTH:0] sum;

`ifdef SEQ_MUL_SIGNED_EN
  logic [WIDTH:0] acc_x;
  logic [WIDTH:0] md_x;

  always_comb begin
    acc_x = {acc[WIDTH-1], acc};
    md_x  = {md[WIDTH-1], md};
    case ({mr[0], q_m1})
      BOOTH_ADD: sum = acc_x + md_x;
      BOOTH_SUB: sum = acc_x - md_x;
      default:   sum = acc_x;
    endcase
  end

  assign q_m1_nxt = mr[0];
`else
  assign sum = {1'b0, acc} + (mr[0] ? {1'b0, md} : '0);
`endif

  // Shift {sum, MR} right by one: sum's top bit (carry or sign) lands in
  // the ACC MSB, and the bit leaving ACC enters the MR MSB.
  assign acc_nxt = sum[WIDTH:1];
  assign mr_nxt  = {sum[0], mr[WIDTH-1:1]};

endmodule

// File: rtl/seq_mul_unit.sv
// seq_mul_unit: iterative WIDTH x WIDTH multiplier, one shift-add step per clock.
//   Ports: clk, rst_n (sync, active low), start/multiplicand/multiplier in;
//   busy, done (1-cycle pulse), product_hi (ACC), product_lo (MR) out.
//   Optional macro SEQ_MUL_SIGNED_EN: two's-complement radix-2 Booth variant.
module seq_mul_unit
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = SEQ_MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mr;
  logic [WIDTH-1:0] md;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mr_nxt;

`ifdef SEQ_MUL_SIGNED_EN
  logic             q_m1;
  logic             q_m1_nxt;
`endif

  mul_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .acc      (acc),
    .mr       (mr),
    .md       (md),
`ifdef SEQ_MUL_SIGNED_EN
    .q_m1     (q_m1),
    .q_m1_nxt (q_m1_nxt),
`endif
    .acc_nxt  (acc_nxt),
    .mr_nxt   (mr_nxt)
  );

  assign product_hi = acc;
  assign product_lo = mr;

  // busy is registered and only drops on the cycle after the done pulse, so
  // it covers RUN, DONE and the done-pulse cycle. Gating start with !busy
  // keeps a start that arrives during the done pulse from being accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      mr    <= '0;
      md    <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
      q_m1  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !busy) begin
            md    <= multiplicand;
            mr    <= multiplier;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
`ifdef SEQ_MUL_SIGNED_EN
            q_m1  <= 1'b0;
`endif
          end
        end

        S_RUN: begin
          acc <= acc_nxt;
          mr  <= mr_nxt;
          cnt <= cnt + CW'(1);
`ifdef SEQ_MUL_SIGNED_EN
          q_m1 <= q_m1_nxt;
`endif
          if (cnt == CNT_LAST) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_unit.sv
// tb_seq_mul_unit: directed bench for seq_mul_unit (WIDTH=16).
//   Table of operand pairs with hand-computed products, plus hand-written
//   sequences for start-while-busy and reset mid-run.
module tb_seq_mul_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] multiplicand = '0;
  logic [W-1:0] multiplier = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] product_hi;
  logic [W-1:0] product_lo;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mul_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product_hi   (product_hi),
    .product_lo   (product_lo)
  );

  typedef struct {
    logic [15:0] md;
    logic [15:0] mr;
    logic [31:0] prod;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one multiply at edge 0 and watch 20 following cycles. If ovr_cyc
  // is nonzero, a second start (2 x 2) is held for one edge after that cycle.
  task automatic run_op(input logic [15:0] md, input logic [15:0] mr,
                        input logic [31:0] exp_prod, input string name,
                        input int ovr_cyc);
    int          done_cnt;
    int          done_cyc;
    logic        busy1;
    logic        busy17;
    logic        busy18;
    logic [31:0] prod_at_done;
    done_cnt     = 0;
    done_cyc     = -1;
    busy1        = 1'b0;
    busy17       = 1'b0;
    busy18       = 1'b1;
    prod_at_done = '0;
    @(negedge clk);
    multiplicand = md;
    multiplier   = mr;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = ~md;
    multiplier   = ~mr;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        done_cyc     = c;
        prod_at_done = {product_hi, product_lo};
      end
      if (c == 1)  busy1  = busy;
      if (c == 17) busy17 = busy;
      if (c == 18) busy18 = busy;
      if (c == ovr_cyc) begin
        multiplicand = 16'd2;
        multiplier   = 16'd2;
        start        = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " done_cycle"}, 32'(done_cyc), 32'd17);
    check({name, " busy_c1"},    {31'd0, busy1},  32'd1);
    check({name, " busy_c17"},   {31'd0, busy17}, 32'd1);
    check({name, " busy_c18"},   {31'd0, busy18}, 32'd0);
    check({name, " prod_done"},  prod_at_done, exp_prod);
    check({name, " prod_held"},  {product_hi, product_lo}, exp_prod);
  endtask

  vec_t vecs[10];

  initial begin
    int done_seen;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F, "3x5"};
    vecs[1] = '{16'h0000, 16'hABCD, 32'h0000_0000, "0xABCD"};
    vecs[2] = '{16'hABCD, 16'h0000, 32'h0000_0000, "ABCDx0"};
    vecs[3] = '{16'h00FF, 16'h0101, 32'h0000_FFFF, "FFx101"};
    vecs[4] = '{16'h1234, 16'h0100, 32'h0012_3400, "1234x100"};
`ifdef SEQ_MUL_SIGNED_EN
    vecs[5] = '{16'hFFFF, 16'hFFFF, 32'h0000_0001, "FFFFxFFFF"};
    vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000, "8000x8000"};
    vecs[7] = '{16'h8000, 16'h0001, 32'hFFFF_8000, "8000x1"};
    vecs[8] = '{16'hFFFF, 16'h0002, 32'hFFFF_FFFE, "FFFFx2"};
    vecs[9] = '{16'h0007, 16'hFFFD, 32'hFFFF_FFEB, "7xFFFD"};
`else
    vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "FFFFxFFFF"};
    vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000, "8000x8000"};
    vecs[7] = '{16'h8000, 16'h0001, 32'h0000_8000, "8000x1"};
    vecs[8] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE, "FFFFx2"};
    vecs[9] = '{16'h0007, 16'hFFFD, 32'h0006_FFEB, "7xFFFD"};
`endif

    // Reset state, with start asserted during reset (reset must win).
    rst_n = 1'b0;
    start = 1'b1;
    multiplicand = 16'h1111;
    multiplier   = 16'h2222;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset prod", {product_hi, product_lo}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post-reset busy", {31'd0, busy}, 32'd0);

    // Table-driven products with full latency/busy checks.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].md, vecs[i].mr, vecs[i].prod, vecs[i].name, 0);
    end

    // Second start during RUN cycle 4 must be ignored.
    run_op(16'h0007, 16'h0009, 32'h0000_003F, "7x9 busy-start", 4);

    // Reset mid-RUN: abort to reset values with no done pulse.
    @(negedge clk);
    multiplicand = 16'h1234;
    multiplier   = 16'h0100;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun busy before reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrun reset busy", {31'd0, busy}, 32'd0);
    check("midrun reset done", {31'd0, done}, 32'd0);
    check("midrun reset prod", {product_hi, product_lo}, 32'd0);
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("midrun no done pulse", 32'(done_seen), 32'd0);
    check("midrun idle busy", {31'd0, busy}, 32'd0);
    run_op(16'h1234, 16'h0100, 32'h0012_3400, "after reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
